// File: rtl/and3_vector_sequencer_if.sv
// Signal bundle between the AND3 sweep sequencer and the gate under test.
// master = sequencer side, slave = gate/bench side.
interface and3_vector_sequencer_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             dut_answer;
    logic             in_a;
    logic             in_b;
    logic             in_c;
    logic [2:0]       vec_idx;
    logic             busy;
    logic             mismatch;
    logic [ERR_W-1:0] err_count;
    logic             done;
    logic             pass;

    modport master (
        input  start, dut_answer,
        output in_a, in_b, in_c, vec_idx, busy, mismatch, err_count, done, pass
    );

    modport slave (
        output start, dut_answer,
        input  in_a, in_b, in_c, vec_idx, busy, mismatch, err_count, done, pass
    );
endinterface

// File: rtl/and3_vector_sequencer.sv
// Sweeps all eight input vectors of a 3-input AND gate, samples the gate once per
// vector and keeps a saturating mismatch count with a done/pass verdict.
module and3_vector_sequencer #(
    parameter int HOLD_CYCLES   = 20,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    and3_vector_sequencer_if.master      bus
);
    localparam int               CNT_W    = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SMP  = CNT_W'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       vec_q,   vec_d;
    logic [ERR_W-1:0] err_q,   err_d;
    logic             mis_q,   mis_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             pass_q,  pass_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            mis_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        err_d   = err_q;
        mis_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    vec_d   = '0;
                    err_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end

            RUN: begin
                if (cnt_q == CNT_SMP && bus.dut_answer != (&vec_q)) begin
                    mis_d = 1'b1;
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                end

                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (vec_q == 3'd7) begin
                        // verdict uses err_d so a sample on this same edge still counts
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                        vec_d   = '0;
                    end else begin
                        vec_d = vec_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_a      = vec_q[2];
    assign bus.in_b      = vec_q[1];
    assign bus.in_c      = vec_q[0];
    assign bus.vec_idx   = vec_q;
    assign bus.busy      = busy_q;
    assign bus.mismatch  = mis_q;
    assign bus.err_count = err_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
endmodule
